// File: rtl/piso_stream_ctrl.sv
// Job sequencer that walks a frozen PISO snapshot and streams its elements
// out over a valid/ready interface, with wrap-around, abort and a done pulse.
`timescale 1ns/1ps
module piso_stream_ctrl #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [AW-1:0]    start_base,
  input  logic [LW-1:0]    start_len,
  input  logic             abort,
  output logic             src_hold,
  output logic [AW-1:0]    r_addr,
  input  logic [WIDTH-1:0] piso_q,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e          r_state;
  logic [LW-1:0]   r_remaining;
  logic            w_fire;
  logic [AW-1:0]   w_addr_next;

  assign w_fire      = m_valid && m_ready;
  assign w_addr_next = (r_addr == LAST_IDX) ? '0 : r_addr + 1'b1;

  // Gated with rst_n so the producer sees "not ready" for the whole reset window.
  assign start_ready = rst_n && (r_state == S_IDLE);
  assign m_data      = piso_q;

  // NOTE: every state and output register uses non-blocking assignments so all
  // flops update together from pre-edge values; blocking here would create
  // order-dependent races between r_remaining, r_addr and the output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_addr      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      done        <= 1'b0;
      src_hold    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start_valid) begin
            r_addr      <= start_base;
            r_remaining <= start_len;
            src_hold    <= 1'b1;
            if (start_len != '0) begin
              r_state <= S_STREAM;
              m_valid <= 1'b1;
              m_last  <= (start_len == LW'(1));
            end else begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end
          end
        end

        S_STREAM: begin
          if (w_fire) begin
            r_remaining <= r_remaining - 1'b1;
          end
          // Abort wins over completion; the address is left where it stood.
          if (abort) begin
            r_state  <= S_IDLE;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            src_hold <= 1'b0;
          end else if (w_fire) begin
            r_addr <= w_addr_next;
            if (r_remaining == LW'(1)) begin
              r_state <= S_DONE;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              done    <= 1'b1;
            end else begin
              m_last <= (r_remaining == LW'(2));
            end
          end
        end

        S_DONE: begin
          r_state  <= S_IDLE;
          done     <= 1'b0;
          src_hold <= 1'b0;
        end

        default: begin
          r_state  <= S_IDLE;
          m_valid  <= 1'b0;
          m_last   <= 1'b0;
          done     <= 1'b0;
          src_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_stream_ctrl.sv
// Randomized bench for piso_stream_ctrl: a behavioural PISO plus a per-job
// model of the expected beat sequence ((base+i) mod DEPTH).
`timescale 1ns/1ps
module tb_piso_stream_ctrl;
  localparam int WIDTH = 10;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [AW-1:0]    start_base = '0;
  logic [LW-1:0]    start_len = '0;
  logic             abort = 1'b0;
  logic             src_hold;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] piso_q;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             m_last;
  logic             done;

  logic [WIDTH-1:0] d_vec    [DEPTH];
  logic [WIDTH-1:0] piso_mem [DEPTH];

  int total = 0;
  int bad   = 0;

  piso_stream_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_base(start_base), .start_len(start_len),
    .abort(abort), .src_hold(src_hold), .r_addr(r_addr),
    .piso_q(piso_q), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .done(done)
  );

  always #5 clk = ~clk;

  // PISO model: recaptures d every edge, read port indexed by r_addr.
  always @(posedge clk) piso_mem <= d_vec;
  assign piso_q = piso_mem[r_addr];

  always @(posedge clk)
    if (rst_n && start_valid && start_ready)
      assert (int'(start_base) < DEPTH && int'(start_len) <= DEPTH)
        else $error("illegal job base=%0d len=%0d", start_base, start_len);

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) d_vec[i] = WIDTH'($urandom);
  endtask

  task automatic check_idle(input string name);
    total++;
    if (start_ready !== 1'b1 || done !== 1'b0 || src_hold !== 1'b0 ||
        m_valid !== 1'b0 || m_last !== 1'b0) begin
      bad++;
      $display("FAIL %s got rdy=%b done=%b hold=%b vld=%b last=%b want 1 0 0 0 0",
               name, start_ready, done, src_hold, m_valid, m_last);
    end
  endtask

  // mode 0: m_ready always 1; mode 1: random m_ready and junk start_valid;
  // mode 2: m_ready pattern 1,0,0,1,0,1 then 1.
  task automatic run_job(input string name, input int base, input int len, input int mode);
    bit [5:0] pat = 6'b101001;
    int idx, cyc, exp_addr;
    bit rdy;
    cyc = 0;
    while (start_ready !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    total++;
    if (start_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_wait got start_ready=%b want 1", name, start_ready);
      return;
    end
    start_valid = 1'b1;
    start_base  = AW'(base);
    start_len   = LW'(len);
    @(posedge clk); #1;
    start_valid = 1'b0;
    if (len == 0) begin
      total++;
      if (done !== 1'b1 || m_valid !== 1'b0 || src_hold !== 1'b1 || start_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s_zero got done=%b vld=%b hold=%b rdy=%b want 1 0 1 0",
                 name, done, m_valid, src_hold, start_ready);
      end
      @(posedge clk); #1;
      check_idle({name, "_after"});
      return;
    end
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < 4 * len + 64) begin
      exp_addr = (base + idx) % DEPTH;
      total++;
      if (m_valid !== 1'b1 || r_addr !== AW'(exp_addr) || m_data !== d_vec[exp_addr] ||
          m_last !== (idx == len - 1) || src_hold !== 1'b1 || done !== 1'b0 ||
          start_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s_beat%0d got vld=%b addr=%0d data=%0d last=%b hold=%b done=%b rdy=%b want 1 %0d %0d %b 1 0 0",
                 name, idx, m_valid, r_addr, m_data, m_last, src_hold, done, start_ready,
                 exp_addr, d_vec[exp_addr], (idx == len - 1));
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc < 6) ? pat[cyc] : 1'b1;
      endcase
      m_ready = rdy;
      if (mode == 1) begin
        start_valid = 1'($urandom_range(0, 1));
        start_base  = AW'($urandom_range(0, DEPTH - 1));
        start_len   = LW'($urandom_range(0, DEPTH));
      end
      @(posedge clk); #1;
      if (rdy) idx++;
      cyc++;
    end
    m_ready     = 1'b0;
    start_valid = 1'b0;
    total++;
    if (idx != len) begin
      bad++;
      $display("FAIL %s_timeout got beats=%0d want %0d", name, idx, len);
      return;
    end
    if (mode == 0 && cyc != len) begin
      bad++;
      $display("FAIL %s_rate got cycles=%0d want %0d", name, cyc, len);
    end else if (done !== 1'b1 || m_valid !== 1'b0 || src_hold !== 1'b1 ||
                 start_ready !== 1'b0 || m_last !== 1'b0) begin
      bad++;
      $display("FAIL %s_done got done=%b vld=%b hold=%b rdy=%b last=%b want 1 0 1 0 0",
               name, done, m_valid, src_hold, start_ready, m_last);
    end
    @(posedge clk); #1;
    check_idle({name, "_idle"});
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (start_ready !== 1'b0 || m_valid !== 1'b0 || r_addr !== '0 || m_last !== 1'b0 ||
        done !== 1'b0 || src_hold !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold got rdy=%b vld=%b addr=%0d last=%b done=%b hold=%b want all 0",
               start_ready, m_valid, r_addr, m_last, done, src_hold);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("reset_release");
  endtask

  task automatic test_basic();
    for (int i = 0; i < DEPTH; i++) d_vec[i] = WIDTH'(i + 100);
    run_job("basic", 0, 4, 0);
  endtask

  task automatic test_wrap();
    fill_random();
    run_job("wrap", 1022, 4, 0);
  endtask

  task automatic test_backpressure();
    fill_random();
    run_job("bp", int'($urandom_range(0, DEPTH - 1)), 3, 2);
  endtask

  task automatic test_zero_full();
    run_job("zero", 77, 0, 0);
    fill_random();
    run_job("full", 5, DEPTH, 0);
  endtask

  task automatic test_abort();
    int base;
    fill_random();
    base = int'($urandom_range(0, DEPTH - 1));
    start_valid = 1'b1;
    start_base  = AW'(base);
    start_len   = LW'(8);
    abort       = 1'b1;           // ignored in IDLE
    m_ready     = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    abort       = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (m_valid !== 1'b1 || r_addr !== AW'((base + i) % DEPTH)) begin
        bad++;
        $display("FAIL abort_beat%0d got vld=%b addr=%0d want 1 %0d",
                 i, m_valid, r_addr, (base + i) % DEPTH);
      end
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort   = 1'b0;
    m_ready = 1'b0;
    check_idle("abort_idle");
    total++;
    if (r_addr !== AW'((base + 2) % DEPTH)) begin
      bad++;
      $display("FAIL abort_addr got %0d want %0d", r_addr, (base + 2) % DEPTH);
    end
    @(posedge clk); #1;
    check_idle("abort_no_done");
    fill_random();
    run_job("post_abort", int'($urandom_range(0, DEPTH - 1)), 5, 1);
  endtask

  task automatic test_reset_mid();
    fill_random();
    start_valid = 1'b1;
    start_base  = AW'($urandom_range(1, DEPTH - 1));
    start_len   = LW'(10);
    m_ready     = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (start_ready !== 1'b0 || m_valid !== 1'b0 || r_addr !== '0 || m_last !== 1'b0 ||
        done !== 1'b0 || src_hold !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got rdy=%b vld=%b addr=%0d last=%b done=%b hold=%b want all 0",
               start_ready, m_valid, r_addr, m_last, done, src_hold);
    end
    m_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("reset_mid_release");
    run_job("post_reset", int'($urandom_range(0, DEPTH - 1)), 3, 0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 20; j++) begin
      fill_random();
      run_job($sformatf("rand%0d", j), int'($urandom_range(0, DEPTH - 1)),
              ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 48)), 1);
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_job("b2b_a", DEPTH - 2, 3, 0);
    run_job("b2b_b", 10, 1, 0);
    run_job("b2b_c", 0, 0, 0);
  endtask

  initial begin
    fill_random();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_full();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_stream_ctrl.md
# piso_stream_ctrl

Sequencer that drains a `PISO_RAM` vector snapshot as a valid/ready element stream.

- Accepts a job on a start handshake: base index and element count.
- Walks `r_addr` across the snapshot with wrap-around.
- Forwards the selected element (`piso_q`) to a downstream consumer with backpressure and a last-beat flag.
- Sits between the vector producer (which drives the PISO `d` bus) and the serial consumer of the coprocessor datapath.

## Interface
Parameters:
- `WIDTH`, 10: element width; must match the PISO instance.
- `DEPTH`, 1024: number of elements in the PISO; any value ≥ 2.
- `AW`, `$clog2(DEPTH)`: address width (derived, not overridden).
- `LW`, `$clog2(DEPTH+1)`: job length width (derived).

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start_valid` in 1: job request.
- `start_ready` out 1: controller can accept a job.
- `start_base` in AW: first element index, must be < DEPTH.
- `start_len` in LW: element count, 0..DEPTH.
- `abort` in 1: cancel the current job.
- `src_hold` out 1: producer must keep `d` frozen while high.
- `r_addr` out AW: registered read index to the PISO.
- `piso_q` in WIDTH: PISO output for `r_addr`.
- `m_data` out WIDTH: combinational passthrough of `piso_q`.
- `m_valid` out 1: beat available.
- `m_ready` in 1: consumer accepts the beat.
- `m_last` out 1: current beat is the final beat of the job.
- `done` out 1: one-cycle pulse when a job completes normally.

## Operation
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - `start_ready=1`, `src_hold=0`, `m_valid=0`.
  - On `start_valid&start_ready`: `r_addr<=start_base`, `remaining<=start_len`.
  - Then go to STREAM if `start_len≠0`, else DONE.
- Producer contract:
  - Drive `d` in the accept cycle and keep it unchanged until `src_hold` falls.
  - The PISO recaptures `d` every edge, so a frozen `d` yields a stable snapshot.
- STREAM:
  - `m_valid=1`, `src_hold=1`, `m_last=(remaining==1)`.
  - On `m_valid&m_ready`: `remaining<=remaining-1`; `r_addr<=(r_addr==DEPTH-1)?0:r_addr+1`.
  - When the beat accepted is the last beat, go to DONE.
- DONE:
  - `done=1` for exactly one cycle, `src_hold=1`, `start_ready=0`.
  - Next state is IDLE.
- `abort` in STREAM:
  - Next state is IDLE, with no `done` pulse.
  - A beat handshaken in the abort cycle counts as delivered.
  - `r_addr` holds its value.
- `abort` in IDLE or DONE is ignored.
- `start_valid` while not in IDLE is ignored; no queueing.
- `start_len > DEPTH` or `start_base ≥ DEPTH` is illegal; behaviour is unspecified, and the bench flags it with an assertion.
- `remaining` is an LW-bit down counter; it never underflows because decrement only occurs when it is ≥ 1.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, `r_addr=0`, `m_valid=0`, `m_last=0`, `done=0`, `src_hold=0`.
- `start_ready` is 0 while `rst_n=0` and 1 in the first cycle after release.
- All outputs except `m_data` are registered or decoded from state only; `m_data` has a combinational path from `piso_q`.
- Latency: accept at edge N → `m_valid=1` with `r_addr=base` in cycle N+1.
- Full-rate throughput: 1 beat/cycle with `m_ready` held high.
- Job of L beats at full rate: `done` in cycle N+L+1; next accept possible at edge N+L+2.
- Zero-length job: accept at N → `done` in cycle N+1 with no beats → IDLE in cycle N+2.
- Backpressure: while `m_valid&!m_ready`, `r_addr`, `m_data` and `m_last` are held stable.
- `m_valid` never drops without a handshake, except on `abort`.
- Wrap-around: after index DEPTH-1 the next index is 0. Example with DEPTH=1024: base=1022, len=4 streams 1022, 1023, 0, 1.
- Reset mid-job: immediate return to the reset values above; any partial stream is discarded.

## Test plan
- Basic job: base=0, len=4, `m_ready=1`, `d[i]=i+100` → `m_data`=100, 101, 102, 103 in consecutive cycles; `m_last` only on 103; `done` one cycle later.
- Wrap job (DEPTH=1024): base=1022, len=4 → `r_addr`=1022, 1023, 0, 1; `m_last` on `r_addr=1`; `src_hold` high from accept+1 through the `done` cycle.
- Backpressure: len=3, `m_ready` toggled 1,0,0,1,0,1 → exactly 3 beats in order; outputs stable during stalls; `done` after the 3rd handshake.
- Zero length and full length:
  - len=0 → `done` at accept+1, `m_valid` never high.
  - len=1024, base=5 → 1024 beats ending at `r_addr=4`.
- Abort and reset:
  - `abort` after the 2nd beat of a len=8 job → IDLE next cycle, no `done`, `start_ready=1`; a new job is then accepted normally.
  - `rst_n` pulse mid-stream → all outputs return to their reset values asynchronously.
